// File: rtl/sparse_pos_loader.sv
// Unpacks 128-bit host words of 16-bit sparse positions into range-checked POSITION_RAM writes.
// Optional feature macro DUMMY_INSERT_EN: pad every successful load to MAX_WEIGHT writes.
module sparse_pos_loader #(
  parameter int WEIGHT         = 66,
  parameter int MAX_WEIGHT     = 75,
  parameter int N              = 17669,
  parameter int LOGW           = 16,
  parameter int LANES          = 8,
  parameter int LOG_MAX_WEIGHT = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      in_valid_i,
  input  logic [LANES*LOGW-1:0]     in_data_i,
  output logic                      in_ready_o,
  output logic                      wr_en_o,
  output logic [LOG_MAX_WEIGHT-1:0] wr_addr_o,
  output logic [LOGW-1:0]           wr_pos_o,
  output logic                      wr_dummy_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);
  localparam int                        LSEL_W   = $clog2(LANES);
  localparam logic [LSEL_W:0]           LANES_C  = (LSEL_W+1)'(LANES);
  localparam logic [LSEL_W:0]           LANE_ONE = (LSEL_W+1)'(1);
  localparam logic [LOG_MAX_WEIGHT-1:0] WEIGHT_C = LOG_MAX_WEIGHT'(WEIGHT);
  localparam logic [LOGW:0]             N_C      = (LOGW+1)'(N);

  if (WEIGHT < 1 || WEIGHT >= MAX_WEIGHT || MAX_WEIGHT >= (1 << LOG_MAX_WEIGHT) ||
      N > (1 << LOGW)) begin : g_bad_cfg
    $error("sparse_pos_loader: inconsistent WEIGHT/MAX_WEIGHT/N/width parameters");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EMIT, S_PAD, S_DONE} state_e;

  state_e                    state_q;
  logic [LANES*LOGW-1:0]     word_q;
  logic [LOG_MAX_WEIGHT-1:0] count_q;
  logic [LSEL_W:0]           lane_q;
  logic                      in_ready_q, wr_en_q, busy_q, done_q, err_q;
  logic [LOG_MAX_WEIGHT-1:0] wr_addr_q;
  logic [LOGW-1:0]           wr_pos_q;
`ifdef DUMMY_INSERT_EN
  logic                      wr_dummy_q;
`endif

  logic [LOGW-1:0] word_lanes [LANES];
  logic [LOGW-1:0] pos_d;
  logic [LSEL_W:0] lane_d;
  logic            pos_ok;
  logic            take_d;

  // Lane 0 is taken straight off the bus in the accepting cycle so its write appears one cycle later.
  always_comb begin
    for (int k = 0; k < LANES; k++) word_lanes[k] = word_q[k*LOGW +: LOGW];
    pos_d  = (state_q == S_LOAD) ? in_data_i[LOGW-1:0] : word_lanes[lane_q[LSEL_W-1:0]];
    lane_d = (state_q == S_LOAD) ? LANE_ONE : lane_q + 1'b1;
    pos_ok = ({1'b0, pos_d} < N_C);
    take_d = (state_q == S_LOAD && in_valid_i) ||
             (state_q == S_EMIT && !err_q && count_q != WEIGHT_C && lane_q != LANES_C);
  end

  // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      // NOTE: the word register is plain flops, not a RAM, so it is cleared here like everything else.
      word_q     <= '0;
      count_q    <= '0;
      lane_q     <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_pos_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef DUMMY_INSERT_EN
      wr_dummy_q <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef DUMMY_INSERT_EN
      wr_dummy_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            count_q    <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid_i) begin
            word_q     <= in_data_i;
            in_ready_q <= 1'b0;
            state_q    <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (err_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (count_q == WEIGHT_C) begin
`ifdef DUMMY_INSERT_EN
            state_q    <= S_PAD;
            wr_en_q    <= 1'b1;
            wr_dummy_q <= 1'b1;
            wr_addr_q  <= count_q;
            wr_pos_q   <= LOGW'(count_q);
            count_q    <= count_q + 1'b1;
`else
            state_q <= S_DONE;
            done_q  <= 1'b1;
`endif
          end else if (lane_q == LANES_C) begin
            state_q    <= S_LOAD;
            in_ready_q <= 1'b1;
          end
        end
`ifdef DUMMY_INSERT_EN
        S_PAD: begin
          if (count_q == LOG_MAX_WEIGHT'(MAX_WEIGHT)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            wr_en_q    <= 1'b1;
            wr_dummy_q <= 1'b1;
            wr_addr_q  <= count_q;
            wr_pos_q   <= LOGW'(count_q);
            count_q    <= count_q + 1'b1;
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // An out-of-range lane writes nothing; err_q then steers EMIT to DONE.
      if (take_d) begin
        lane_q <= lane_d;
        if (pos_ok) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= count_q;
          wr_pos_q  <= pos_d;
          count_q   <= count_q + 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign in_ready_o = in_ready_q;
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_pos_o   = wr_pos_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
`ifdef DUMMY_INSERT_EN
  assign wr_dummy_o = wr_dummy_q;
`else
  assign wr_dummy_o = 1'b0;
`endif

endmodule

// File: tb/tb_sparse_pos_loader.sv
// Scoreboard bench for sparse_pos_loader: a list-level model predicts the RAM write stream and done/err.
// Honours DUMMY_INSERT_EN the same way as the design.
`timescale 1ns/1ps
module tb_sparse_pos_loader;
  localparam int WEIGHT     = 66;
  localparam int MAX_WEIGHT = 75;
  localparam int N          = 17669;
  localparam int LOGW       = 16;
  localparam int LANES      = 8;
  localparam int LMW        = 7;
  localparam int SLOTS      = 9 * LANES;

  logic                  clk = 1'b0;
  logic                  rst, start_i, in_valid_i;
  logic [LANES*LOGW-1:0] in_data_i;
  logic                  in_ready_o, wr_en_o, wr_dummy_o, busy_o, done_o, err_o;
  logic [LMW-1:0]        wr_addr_o;
  logic [LOGW-1:0]       wr_pos_o;

  sparse_pos_loader #(
    .WEIGHT(WEIGHT), .MAX_WEIGHT(MAX_WEIGHT), .N(N), .LOGW(LOGW), .LANES(LANES), .LOG_MAX_WEIGHT(LMW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_pos_o(wr_pos_o),
    .wr_dummy_o(wr_dummy_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            is_done;
    logic            err;
    logic            dummy;
    logic [LMW-1:0]  addr;
    logic [LOGW-1:0] pos;
  } ev_t;

  ev_t             exp_q[$];
  ev_t             mon_act, mon_exp;
  int              vectors = 0;
  int              miscompares = 0;
  int              cyc = 0;
  logic [LOGW-1:0] pos_tab [SLOTS];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk_ev(input bit is_done, input bit err, input bit dummy, input int addr,
                                input int pos);
    ev_t e;
    e.is_done = is_done;
    e.err     = err;
    e.dummy   = dummy;
    e.addr    = LMW'(addr);
    e.pos     = LOGW'(pos);
    return e;
  endfunction

  // Reference: walk the flat position list; stop at the first illegal value or after WEIGHT writes.
  function automatic int build_expect(output bit err);
    int cnt   = 0;
    int words = 0;
    err = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (cnt == WEIGHT || err) continue;
      words = i / LANES + 1;
      if (int'(pos_tab[i]) >= N) err = 1'b1;
      else begin
        exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b0, cnt, int'(pos_tab[i])));
        cnt++;
      end
    end
`ifdef DUMMY_INSERT_EN
    if (!err) for (int a = WEIGHT; a < MAX_WEIGHT; a++) exp_q.push_back(mk_ev(1'b0, 1'b0, 1'b1, a, a));
`endif
    exp_q.push_back(mk_ev(1'b1, err, 1'b0, 0, 0));
    return words;
  endfunction

  always @(negedge clk) begin
    if (!rst && (wr_en_o || done_o)) begin
      mon_act.is_done = done_o;
      mon_act.err     = err_o;
      mon_act.dummy   = wr_dummy_o;
      mon_act.addr    = done_o ? '0 : wr_addr_o;
      mon_act.pos     = done_o ? '0 : wr_pos_o;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got 0x%0h, want no output", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check(done_o ? "sb_done" : "sb_write", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  task automatic fill_random(input int err_idx);
    for (int i = 0; i < SLOTS; i++) pos_tab[i] = LOGW'($urandom_range(N - 1, 0));
    if (err_idx >= 0) pos_tab[err_idx] = LOGW'($urandom_range(65535, N));
  endtask

  task automatic run_load(input bit gaps, input bit poke, output int cycles);
    int nw, t0, prev_hs, k;
    bit eb, aborted;
    nw      = build_expect(eb);
    aborted = 1'b0;
    prev_hs = 0;
    cycles  = -1;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    t0 = cyc;
    check("load_entry", {busy_o, in_ready_o, err_o, done_o}, 4'b1100);
    for (int w = 0; w < nw; w++) begin
      if (aborted) continue;
      for (int j = 0; j < LANES; j++) in_data_i[j*LOGW +: LOGW] = pos_tab[w*LANES + j];
      in_valid_i = 1'b1;
      k = 0;
      while (!in_ready_o && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready_o) begin
        vectors++;
        miscompares++;
        $display("FAIL ready_timeout: got in_ready_o=0 for 50 cycles, want 1 (word %0d)", w);
        aborted = 1'b1;
        continue;
      end
      if (w > 0 && !gaps) check("ready_interval", cyc - prev_hs, 9);
      prev_hs = cyc;
      @(negedge clk);
      check("lane0_latency", {in_ready_o, wr_en_o}, {1'b0, int'(pos_tab[w*LANES]) < N});
      if (poke && w == 0 && nw > 1) begin
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
      end
      if (gaps && w < nw - 1) begin
        in_valid_i = 1'b0;
        repeat ($urandom_range(3, 0)) @(negedge clk);
      end
    end
    in_valid_i = 1'b0;
    k = 0;
    while (!done_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done_o) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got done_o=0 for 200 cycles, want a done pulse");
    end else begin
      cycles = cyc - t0;
      check("err_at_done", err_o, eb);
      @(negedge clk);
      check("done_one_cycle", {done_o, busy_o, err_o}, {2'b00, eb});
    end
    check("sb_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want $finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c_spec, c_a, c_b, c_tmp, err_idx;
    bit eb;
    rst = 1'b1;
    start_i = 1'b0;
    in_valid_i = 1'b0;
    in_data_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready_o, wr_en_o, wr_addr_o, wr_pos_o, wr_dummy_o, busy_o, done_o, err_o}, 0);
    rst = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = '1;
    repeat (3) @(negedge clk);
    check("idle_ignores_valid", {in_ready_o, wr_en_o, wr_addr_o, wr_pos_o, wr_dummy_o, busy_o, done_o, err_o}, 0);
    in_valid_i = 1'b0;

    // Ascending 0..71: only the first 66 land; start_i poked mid-load.
    for (int i = 0; i < SLOTS; i++) pos_tab[i] = LOGW'(i);
    run_load(1'b0, 1'b1, c_spec);

    // Illegal N in lane 3 of the first word: three writes, then error.
    fill_random(-1);
    pos_tab[3] = LOGW'(N);
    run_load(1'b0, 1'b0, c_tmp);
    repeat (5) @(negedge clk);
    check("err_sticky", {err_o, busy_o}, 2'b10);

    // N-1 is legal; valid held high throughout.
    fill_random(-1);
    for (int i = 0; i < SLOTS; i += 5) pos_tab[i] = LOGW'(N - 1);
    run_load(1'b0, 1'b0, c_a);
    fill_random(-1);
    run_load(1'b0, 1'b0, c_b);
    check("const_load_time", c_b, c_a);
    check("const_load_time_spec", c_spec, c_a);

    // Randomised loads with host gaps and occasional illegal positions.
    for (int it = 0; it < 20; it++) begin
      err_idx = ($urandom_range(2, 0) == 0) ? int'($urandom_range(SLOTS - 1, 0)) : -1;
      fill_random(err_idx);
      run_load(1'b1, (err_idx < 0), c_tmp);
    end

    // Reset in the middle of EMIT, then a clean load.
    fill_random(-1);
    void'(build_expect(eb));
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int j = 0; j < LANES; j++) in_data_i[j*LOGW +: LOGW] = pos_tab[j];
    in_valid_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_emit_active", {busy_o, wr_en_o}, 2'b11);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", {in_ready_o, wr_en_o, wr_addr_o, wr_pos_o, wr_dummy_o, busy_o, done_o, err_o}, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    fill_random(-1);
    run_load(1'b0, 1'b0, c_tmp);
    check("load_after_rst_time", c_tmp, c_a);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
